la_div_unit: RTL and testbench

//  Parametrised iterative integer divider for the EX stage (div.w/mod.w/div.wu/mod.wu).

---
 rtl/la_div_pkg.sv | 23 ++
 rtl/la_div_step.sv | 36 +++
 rtl/la_div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_la_div_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/la_div_pkg.sv
// -----------------------------------------------------------------------------
// la_div_pkg
// Purpose : shared constants for the iterative EX-stage divider.
//           It holds the 2-bit FSM state encodings, the result-ready
//           levels and the default width of the {remainder, quotient} bus.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package la_div_pkg;

    typedef logic [1:0] div_state_t;

    localparam div_state_t DIV_IDLE = 2'b00;
    localparam div_state_t DIV_ZERO = 2'b01;
    localparam div_state_t DIV_BUSY = 2'b10;
    localparam div_state_t DIV_DONE = 2'b11;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    // Width of the {remainder, quotient} bus at the default 32-bit operand width.
    localparam int DOUBLE_REG_BUS_W = 64;

endpackage

// File: rtl/la_div_step.sv
// -----------------------------------------------------------------------------
// la_div_step
// Purpose : one combinational restoring-division step. It shifts the next
//           dividend bit into the partial remainder, compares the result with
//           the divisor and subtracts when the divisor fits.
// Ports   : i_rem[WIDTH:0]      partial remainder in
//           i_dvd_bit           next dividend bit (MSB first)
//           i_divisor[WIDTH-1:0] magnitude of the divisor
//           o_rem[WIDTH:0]      partial remainder out
//           o_q_bit             quotient bit produced by this step
// -----------------------------------------------------------------------------
module la_div_step
    import la_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_dvs;

    assign w_shift = {i_rem[WIDTH-1:0], i_dvd_bit};
    assign w_dvs   = {1'b0, i_divisor};

    // If the top remainder bit is set, the shifted value is larger than any
    // divisor. This cannot occur while the remainder stays below the
    // divisor, but folding that bit in keeps the compare exact.
    assign o_q_bit = i_rem[WIDTH] | (w_shift >= w_dvs);
    assign o_rem   = o_q_bit ? (w_shift - w_dvs) : w_shift;

endmodule

// File: rtl/la_div_unit.sv
// -----------------------------------------------------------------------------
// la_div_unit
// Purpose : parametrised iterative restoring divider for div.w/mod.w/div.wu/
//           mod.wu. It retires BITS_PER_CYCLE quotient bits per cycle and
//           raises ready_o N+1 cycles after the start, where
//           N = WIDTH/BITS_PER_CYCLE. A zero divisor gives quotient = all
//           ones and remainder = dividend after 2 cycles.
// Ports   : clk, rst (synchronous, active-high)
//           signed_div_i, opdata1_i (dividend), opdata2_i (divisor)
//           start_i (held until ready_o), cancel_i (flush, overrides start)
//           result_o {remainder, quotient}, ready_o, busy_o
//           stallreq_o (combinational stall request to CTRL)
//           div_by_zero_o (present only when LA_DIV_ZERO_FLAG_EN is defined)
// -----------------------------------------------------------------------------
module la_div_unit
    import la_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               cancel_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               stallreq_o
`ifdef LA_DIV_ZERO_FLAG_EN
    ,
    output logic               div_by_zero_o
`endif
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Conditional two's-complement negation. It is used both for operand
    // magnitudes and for the final sign fix-up.
    function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    div_state_t           r_state;
    div_state_t           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_dividend;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic                 r_quo_sign;
    logic                 r_rem_sign;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_ready;
    logic                 r_busy;

    logic                 w_sign1;
    logic                 w_sign2;
    logic                 w_dvs_zero;
    logic [WIDTH:0]       w_rem [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] w_qbits;
    logic [WIDTH-1:0]     w_quo_nxt;

    assign w_sign1    = signed_div_i & opdata1_i[WIDTH-1];
    assign w_sign2    = signed_div_i & opdata2_i[WIDTH-1];
    assign w_dvs_zero = (opdata2_i == {WIDTH{1'b0}});

    // Chain of restoring steps. Each step consumes one dividend bit, MSB first.
    assign w_rem[0] = r_rem;
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        la_div_step #(.WIDTH(WIDTH)) u_step (
            .i_rem     (w_rem[k]),
            .i_dvd_bit (r_dividend[WIDTH-1-k]),
            .i_divisor (r_divisor),
            .o_rem     (w_rem[k+1]),
            .o_q_bit   (w_qbits[BITS_PER_CYCLE-1-k])
        );
    end

    assign w_quo_nxt = {r_quo[WIDTH-BITS_PER_CYCLE-1:0], w_qbits};

    // Next-state logic. A cancel request wins over everything except reset.
    always_comb begin
        w_state_nxt = r_state;
        if (cancel_i) begin
            w_state_nxt = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = w_dvs_zero ? DIV_ZERO : DIV_BUSY;
                    end else begin
                        w_state_nxt = DIV_IDLE;
                    end
                end
                DIV_ZERO: w_state_nxt = DIV_DONE;
                DIV_BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = DIV_DONE;
                    end else begin
                        w_state_nxt = DIV_BUSY;
                    end
                end
                DIV_DONE: begin
                    if (start_i) begin
                        w_state_nxt = DIV_DONE;
                    end else begin
                        w_state_nxt = DIV_IDLE;
                    end
                end
                default: w_state_nxt = DIV_IDLE;
            endcase
        end
    end

    // State, status flags, operand latch, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_dividend <= {WIDTH{1'b0}};
            r_divisor  <= {WIDTH{1'b0}};
            r_rem      <= {(WIDTH+1){1'b0}};
            r_quo      <= {WIDTH{1'b0}};
            r_quo_sign <= 1'b0;
            r_rem_sign <= 1'b0;
            r_result   <= {(2*WIDTH){1'b0}};
            r_ready    <= DIV_RESULT_NOT_READY;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
            r_busy  <= (w_state_nxt == DIV_BUSY) || (w_state_nxt == DIV_ZERO);
            if (cancel_i) begin
                r_cnt <= {CNT_W{1'b0}};
            end else begin
                case (r_state)
                    DIV_IDLE: begin
                        if (start_i) begin
                            r_cnt      <= {CNT_W{1'b0}};
                            r_rem      <= {(WIDTH+1){1'b0}};
                            r_quo      <= {WIDTH{1'b0}};
                            r_quo_sign <= w_sign1 ^ w_sign2;
                            r_rem_sign <= w_sign1;
                            // The zero path returns the raw dividend as the remainder.
                            r_dividend <= w_dvs_zero ? opdata1_i : f_cond_neg(opdata1_i, w_sign1);
                            r_divisor  <= f_cond_neg(opdata2_i, w_sign2);
                        end
                    end
                    DIV_ZERO: begin
                        r_result <= {r_dividend, {WIDTH{1'b1}}};
                    end
                    DIV_BUSY: begin
                        r_rem      <= w_rem[BITS_PER_CYCLE];
                        r_quo      <= w_quo_nxt;
                        r_dividend <= r_dividend << BITS_PER_CYCLE;
                        r_cnt      <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_result <= {f_cond_neg(w_rem[BITS_PER_CYCLE][WIDTH-1:0], r_rem_sign),
                                         f_cond_neg(w_quo_nxt, r_quo_sign)};
                        end
                    end
                    DIV_DONE: begin
                        r_cnt <= r_cnt;
                    end
                    default: begin
                        r_cnt <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

`ifdef LA_DIV_ZERO_FLAG_EN
    logic r_dbz;

    // The flag is set on entry to DONE from ZERO and held only while DONE is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbz <= 1'b0;
        end else begin
            r_dbz <= ((r_state == DIV_ZERO) && (w_state_nxt == DIV_DONE)) ||
                     ((r_state == DIV_DONE) && (w_state_nxt == DIV_DONE) && r_dbz);
        end
    end

    assign div_by_zero_o = r_dbz;
`endif

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign busy_o     = r_busy;
    assign stallreq_o = start_i & ~r_ready & ~cancel_i;

endmodule

// File: tb/tb_la_div_unit.sv
// -----------------------------------------------------------------------------
// tb_la_div_unit
// Purpose : self-checking bench for la_div_unit. Two instances share one
//           stimulus stream: u_dut1 retires one bit per cycle and u_dut4
//           retires four. Expected results come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_la_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        cancel;
    logic [63:0] result1, result4;
    logic        ready1, ready4, busy1, busy4, stall1, stall4;
`ifdef LA_DIV_ZERO_FLAG_EN
    logic        dbz1, dbz4;
`endif

    int checks = 0;
    int errors = 0;

    la_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .cancel_i(cancel), .result_o(result1), .ready_o(ready1),
        .busy_o(busy1),
`ifdef LA_DIV_ZERO_FLAG_EN
        .div_by_zero_o(dbz1),
`endif
        .stallreq_o(stall1)
    );

    la_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .cancel_i(cancel), .result_o(result4), .ready_o(ready4),
        .busy_o(busy4),
`ifdef LA_DIV_ZERO_FLAG_EN
        .div_by_zero_o(dbz4),
`endif
        .stallreq_o(stall4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {remainder, quotient}: truncating integer division, where the
    // remainder takes the sign of the dividend.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    logic [63:0] last_exp;

    // Entered and left #1 after a rising edge.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int lat1, lat4, stall_cnt;
        bit zero;
        exp = ref_div(sgn, a, b);
        zero = (b == 32'd0);
        lat1 = 0; lat4 = 0; stall_cnt = 0;
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        #1;
        if (stall1) stall_cnt++;
        for (int c = 1; c <= 40 && (lat1 == 0 || lat4 == 0); c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk({tag, "_busy1"}, 64'(busy1), 64'd1);
                chk({tag, "_busy4"}, 64'(busy4), 64'd1);
                op1 = $urandom; op2 = $urandom; signed_div = ~sgn;
            end
            if (stall1) stall_cnt++;
            if (ready1 && lat1 == 0) lat1 = c;
            if (ready4 && lat4 == 0) lat4 = c;
        end
        chk({tag, "_lat1"}, 64'(lat1), zero ? 64'd2 : 64'd33);
        chk({tag, "_lat4"}, 64'(lat4), zero ? 64'd2 : 64'd9);
        chk({tag, "_stall1"}, 64'(stall_cnt), zero ? 64'd2 : 64'd33);
        chk({tag, "_res1"}, result1, exp);
        chk({tag, "_res4"}, result4, exp);
`ifdef LA_DIV_ZERO_FLAG_EN
        chk({tag, "_dbz1"}, 64'(dbz1), 64'(zero));
        chk({tag, "_dbz4"}, 64'(dbz4), 64'(zero));
`endif
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_rdy1"}, 64'(ready1), 64'd0);
        chk({tag, "_idle_rdy4"}, 64'(ready4), 64'd0);
        chk({tag, "_idle_res1"}, result1, exp);
        last_exp = exp;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          sel;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; op1 = 32'd0; op2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res1", result1, 64'd0);
        chk("rst_res4", result4, 64'd0);
        chk("rst_rdy", {62'd0, ready1, ready4}, 64'd0);
        chk("rst_busy", {62'd0, busy1, busy4}, 64'd0);
        chk("rst_stall", {62'd0, stall1, stall4}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("u_dz", 1'b0, 32'h1234, 32'd0);
        run_op("s_dz", 1'b1, 32'hFFFF_1234, 32'd0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u_ff_10", 1'b0, 32'hFFFF_FFFF, 32'h10);

        for (int i = 0; i < 10; i++) begin
            sel = $urandom_range(0, 3);
            ra  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            case (sel)
                0: rb = $urandom_range(1, 15);
                1: rb = 32'd0;
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 7);
                default: rb = $urandom;
            endcase
            run_op("rand", rs, ra, rb);
        end

        // Cancel at BUSY cycle 10. u_dut4 is already in DONE by then.
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        chk("cxl_rdy1", 64'(ready1), 64'd0);
        chk("cxl_busy1", 64'(busy1), 64'd0);
        chk("cxl_rdy4", 64'(ready4), 64'd0);
        chk("cxl_res1", result1, last_exp);
        chk("cxl_res4", result4, ref_div(1'b0, 32'd1000, 32'd7));
        cancel = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_op("u9_3", 1'b0, 32'd9, 32'd3);

        // Reset during BUSY clears every output on the next cycle.
        signed_div = 1'b0; op1 = 32'd12345; op2 = 32'd11; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mrst_res1", result1, 64'd0);
        chk("mrst_res4", result4, 64'd0);
        chk("mrst_flags", {60'd0, ready1, ready4, busy1, busy4}, 64'd0);
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_idle", {60'd0, ready1, ready4, busy1, busy4}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
